// File: rtl/uart_rx_engine.sv
// UART receive engine: 16x-oversampled deserialiser with runtime parity and
// stop-bit configuration, per-frame error tagging and a first-word-fall-through
// RX FIFO whose head entry is presented from registers.
//
// Handshake: an entry is transferred on every rising clk edge where rd_valid
// and rd_ready are both high. rd_valid never depends on rd_ready, and the
// rd_data/rd_perr/rd_ferr outputs hold steady while rd_valid is high and
// rd_ready is low.
module uart_rx_engine #(
  parameter int DATA_W  = 8,
  parameter int FIFO_DP = 16,
  parameter int DIV_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DIV_W-1:0]           cfg_div,
  input  logic [1:0]                 cfg_parity,
  input  logic                       cfg_stop2,
  input  logic                       rxd,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_perr,
  output logic                       rd_ferr,
  output logic [$clog2(FIFO_DP):0]   fifo_cnt,
  output logic                       overrun,
  input  logic                       ovr_clr,
  output logic [2:0]                 dbg_state
);

  localparam int AW = $clog2(FIFO_DP);
  localparam int EW = DATA_W + 2;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;

  // receiver state
  logic [2:0]        state;
  logic              sync1;
  logic              rxd_s;
  logic              armed;
  logic [DIV_W-1:0]  tick_cnt;
  logic [DIV_W-1:0]  div_q;
  logic [1:0]        par_q;
  logic              stop2_q;
  logic [3:0]        samp_cnt;
  logic [BW-1:0]     bit_idx;
  logic              s7;
  logic              s8;
  logic [DATA_W-1:0] shreg;
  logic              perr_q;
  logic              ferr_q;

  logic              tick;
  logic              vote;
  logic              at_mid;
  logic              at_end;
  logic              par_on;

  // FIFO state
  logic [EW-1:0]     mem [FIFO_DP];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [EW-1:0]     head_q;

  logic              push;
  logic [EW-1:0]     push_word;
  logic              pop;
  logic              full;
  logic              push_ok;
  logic              drop;
  logic [AW:0]       rd_ptr_n;
  logic [AW:0]       cnt_after_pop;
  logic [AW:0]       cnt_n;

  assign dbg_state = state;

  // rxd is asynchronous; two flops, preset to the idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxd_s <= sync1;
    end
  end

  // Oversample tick generator; parked at the live divisor while idle so the
  // first tick of a frame lands cfg_div+1 clocks after start detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (state == S_IDLE) begin
      tick_cnt <= cfg_div;
    end else if (tick) begin
      tick_cnt <= div_q;
    end else begin
      tick_cnt <= tick_cnt - DIV_W'(1);
    end
  end

  assign tick   = (state != S_IDLE) && (tick_cnt == '0);
  assign vote   = (s7 & s8) | (s7 & rxd_s) | (s8 & rxd_s);
  assign at_mid = tick && (samp_cnt == 4'd9);
  assign at_end = tick && (samp_cnt == 4'd15);
  assign par_on = (par_q == 2'b01) || (par_q == 2'b10);

  // Frame completion: the stop check happens at sample 9 and the frame is
  // pushed right then, so the receiver is back in IDLE half a bit early
  always_comb begin
    push      = 1'b0;
    push_word = {ferr_q | ~vote, perr_q, shreg};
    if (at_mid && (((state == S_STOP) && !stop2_q) || (state == S_STOP2))) begin
      push = 1'b1;
    end
  end

  // Receive FSM: start detect, majority vote per bit, shifting and error tagging
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      armed    <= 1'b0;
      div_q    <= '0;
      par_q    <= 2'b00;
      stop2_q  <= 1'b0;
      samp_cnt <= 4'd0;
      bit_idx  <= '0;
      s7       <= 1'b1;
      s8       <= 1'b1;
      shreg    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (tick) begin
        samp_cnt <= samp_cnt + 4'd1;
        if (samp_cnt == 4'd7) s7 <= rxd_s;
        if (samp_cnt == 4'd8) s8 <= rxd_s;
      end
      case (state)
        S_IDLE: begin
          // a falling edge only counts once the line has been seen high,
          // which also holds off a new frame while a break is still low
          if (rxd_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state    <= S_START;
            armed    <= 1'b0;
            samp_cnt <= 4'd0;
            bit_idx  <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            div_q    <= cfg_div;
            par_q    <= cfg_parity;
            stop2_q  <= cfg_stop2;
          end
        end
        S_START: begin
          if (at_mid && vote) begin
            state <= S_IDLE;
          end else if (at_end) begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (at_mid) begin
            shreg <= {vote, shreg[DATA_W-1:1]};
          end
          if (at_end) begin
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
              state   <= par_on ? S_PARITY : S_STOP;
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        S_PARITY: begin
          if (at_mid) begin
            perr_q <= (par_q == 2'b01) ? (^shreg ^ vote) : ~(^shreg ^ vote);
          end
          if (at_end) begin
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (at_mid) begin
            ferr_q <= ferr_q | ~vote;
            if (!stop2_q) state <= S_IDLE;
          end else if (at_end) begin
            state <= S_STOP2;
          end
        end
        S_STOP2: begin
          if (at_mid) begin
            ferr_q <= ferr_q | ~vote;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO bookkeeping; a full FIFO still accepts a push when the head pops
  assign fifo_cnt      = wr_ptr - rd_ptr;
  assign rd_valid      = (fifo_cnt != '0);
  assign full          = (fifo_cnt == (AW+1)'(FIFO_DP));
  assign pop           = rd_valid && rd_ready;
  assign push_ok       = push && (!full || pop);
  assign drop          = push && full && !pop;
  assign rd_ptr_n      = rd_ptr + (AW+1)'(pop);
  assign cnt_after_pop = fifo_cnt - (AW+1)'(pop);
  assign cnt_n         = cnt_after_pop + (AW+1)'(push_ok);

  // Entry storage; not reset because only written slots are ever read
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_word;
    end
  end

  // Pointers and the registered head entry; a push into an otherwise empty
  // FIFO bypasses the array so it appears on rd_* the next clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      rd_ptr <= rd_ptr_n;
      if (cnt_n != '0) begin
        head_q <= (cnt_after_pop == '0) ? push_word : mem[rd_ptr_n[AW-1:0]];
      end
    end
  end

  assign rd_data = head_q[DATA_W-1:0];
  assign rd_perr = head_q[DATA_W];
  assign rd_ferr = head_q[DATA_W+1];

  // Sticky overrun flag; a drop in the same clock as a clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Testbench for uart_rx_engine: an 8-bit instance and a 9-bit instance share
// the serial line and configuration; each has its own consumer.
module tb_uart_rx_engine;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] cfg_div;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        rxd;
  logic        ovr_clr;

  logic        rdy8, v8, perr8, ferr8, ovr8;
  logic [7:0]  d8;
  logic [4:0]  cnt8;
  logic [2:0]  st8;

  logic        rdy9, v9, perr9, ferr9, ovr9;
  logic [8:0]  d9;
  logic [4:0]  cnt9;
  logic [2:0]  st9;

  int tests = 0;
  int fails = 0;
  bit send_done;
  logic [10:0] exp_q[$];

  uart_rx_engine #(.DATA_W(8), .FIFO_DP(16), .DIV_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .rxd(rxd), .rd_valid(v8), .rd_ready(rdy8),
    .rd_data(d8), .rd_perr(perr8), .rd_ferr(ferr8), .fifo_cnt(cnt8),
    .overrun(ovr8), .ovr_clr(ovr_clr), .dbg_state(st8)
  );

  uart_rx_engine #(.DATA_W(9), .FIFO_DP(16), .DIV_W(16)) dut9 (
    .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .rxd(rxd), .rd_valid(v9), .rd_ready(rdy9),
    .rd_data(d9), .rd_perr(perr9), .rd_ferr(ferr9), .fifo_cnt(cnt9),
    .overrun(ovr9), .ovr_clr(ovr_clr), .dbg_state(st9)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] par;
    logic       pbit;
    logic       stop1;
    logic       stop2;
    logic       s2;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: frame fields -> {ferr, perr, data} by counting ones
  function automatic logic [10:0] model(input logic [8:0] d, input logic [1:0] par,
                                        input logic pbit, input logic stop1,
                                        input logic stop2, input logic s2);
    int ones;
    logic pe, fe;
    ones = $countones(d) + int'(pbit);
    pe = 1'b0;
    if (par == 2'b01) pe = (ones % 2) != 0;
    if (par == 2'b10) pe = (ones % 2) == 0;
    fe = !stop1 || (s2 && !stop2);
    return {fe, pe, d};
  endfunction

  // driver tasks (all timing on falling edges)
  task automatic drive_bit(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] d, input int nbits, input logic [1:0] par,
                            input logic pbit, input logic stop1, input logic stop2,
                            input logic s2, input int bclk, input bit scramble,
                            input int idle_bits);
    drive_bit(1'b0, bclk);
    if (scramble) begin
      cfg_parity = 2'($urandom_range(0, 3));
      cfg_stop2  = 1'($urandom_range(0, 1));
      cfg_div    = 16'($urandom_range(0, 60));
    end
    for (int i = 0; i < nbits; i++) drive_bit(d[i], bclk);
    if (par == 2'b01 || par == 2'b10) drive_bit(pbit, bclk);
    drive_bit(stop1, bclk);
    if (s2) drive_bit(stop2, bclk);
    drive_bit(1'b1, idle_bits * bclk);
  endtask

  task automatic read8(input string name, input logic [7:0] ed, input logic ep, input logic ef);
    int n = 0;
    while (!v8 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, 32'(v8), 1);
    if (v8) begin
      check({name, "_data"}, 32'(d8), 32'(ed));
      check({name, "_perr"}, 32'(perr8), 32'(ep));
      check({name, "_ferr"}, 32'(ferr8), 32'(ef));
      rdy8 = 1'b1;
      @(negedge clk);
      rdy8 = 1'b0;
    end
  endtask

  // scoreboard consumer with random rd_ready; decides ready at the falling
  // edge, so an accepted entry is the one visible now
  task automatic reader(input bit nine, input string name);
    int idle = 0;
    logic v, r;
    logic [10:0] got;
    while (!(send_done && exp_q.size() == 0) && idle < 3000) begin
      @(negedge clk);
      v   = nine ? v9 : v8;
      got = nine ? {ferr9, perr9, d9} : {ferr8, perr8, 1'b0, d8};
      r   = 1'($urandom_range(0, 1));
      if (nine) rdy9 = r; else rdy8 = r;
      if (v && r) begin
        idle = 0;
        if (exp_q.size() == 0) check({name, "_extra"}, 32'(exp_q.size()), 1);
        else check(name, 32'(got), 32'(exp_q.pop_front()));
      end else if (send_done) begin
        idle++;
      end
    end
    rdy8 = 1'b0;
    rdy9 = 1'b0;
    check({name, "_drained"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    logic [8:0] rd;
    logic [1:0] rp;
    logic rb, rs1, rs2, rss;
    int rdiv;

    vecs[0]  = '{8'hA5, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{8'h3C, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[2]  = '{8'h3C, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0};
    vecs[3]  = '{8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1};
    vecs[4]  = '{8'h55, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1};
    vecs[5]  = '{8'h01, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[6]  = '{8'h80, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0};
    vecs[7]  = '{8'hC3, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0};
    vecs[8]  = '{8'h5A, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
    vecs[9]  = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{8'hFF, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1};

    rxd = 1'b1; cfg_div = 16'd53; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    rdy8 = 1'b0; rdy9 = 1'b0; ovr_clr = 1'b0; rst_n = 1'b0;
    repeat (5) @(negedge clk);

    // reset state
    check("rst_valid8", 32'(v8), 0);
    check("rst_data8", 32'(d8), 0);
    check("rst_errs8", 32'({perr8, ferr8}), 0);
    check("rst_cnt8", 32'(cnt8), 0);
    check("rst_ovr8", 32'(ovr8), 0);
    check("rst_state8", 32'(st8), 0);
    check("rst_out9", 32'({v9, d9, cnt9, ovr9}), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // even parity 0xA5 at the full 864-clock bit time
    cfg_parity = 2'b01;
    send_frame(9'h0A5, 8, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 864, 1'b0, 1);
    check("a5_cnt", 32'(cnt8), 1);
    read8("a5", 8'hA5, 1'b0, 1'b0);

    // 2us low glitch on idle line
    rxd = 1'b0;
    repeat (200) @(negedge clk);
    rxd = 1'b1;
    repeat (1000) @(negedge clk);
    check("glitch_cnt", 32'(cnt8), 0);
    check("glitch_state", 32'(st8), 0);

    // table-driven vectors at a faster bit time
    cfg_div = 16'd1;
    for (int i = 0; i < 11; i++) begin
      cfg_parity = vecs[i].par;
      cfg_stop2  = vecs[i].s2;
      send_frame({1'b0, vecs[i].data}, 8, vecs[i].par, vecs[i].pbit, vecs[i].stop1,
                 vecs[i].stop2, vecs[i].s2, 32, 1'b0, 2);
      read8($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
      check($sformatf("vec%0d_cnt", i), 32'(cnt8), 0);
    end

    // overflow: 17 frames with no consumer
    cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send_frame(9'(i), 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32, 1'b0, 1);
    end
    repeat (20) @(negedge clk);
    check("ovf_cnt", 32'(cnt8), 16);
    check("ovf_flag", 32'(ovr8), 1);
    for (int i = 0; i < 16; i++) read8($sformatf("ovf_rd%0d", i), 8'(i), 1'b0, 1'b0);
    check("ovf_empty", 32'(cnt8), 0);
    check("ovf_sticky", 32'(ovr8), 1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovf_clr", 32'(ovr8), 0);

    // reset in the middle of the data bits, then a clean frame
    send_frame(9'h012, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32, 1'b0, 1);
    drive_bit(1'b0, 32);
    drive_bit(1'b1, 32);
    drive_bit(1'b0, 32);
    drive_bit(1'b1, 16);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_cnt", 32'(cnt8), 0);
    check("midrst_valid", 32'(v8), 0);
    rxd = 1'b1;
    rst_n = 1'b1;
    drive_bit(1'b1, 12 * 32);
    check("midrst_after", 32'(cnt8), 0);
    send_frame(9'h06B, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32, 1'b0, 1);
    read8("midrst_next", 8'h6B, 1'b0, 1'b0);

    // randomized frames against the reference model; cfg scrambled mid-frame
    send_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          rd   = 9'($urandom_range(0, 255));
          rp   = 2'($urandom_range(0, 3));
          rb   = 1'($urandom_range(0, 1));
          rs1  = ($urandom_range(0, 5) != 0);
          rs2  = ($urandom_range(0, 3) != 0);
          rss  = 1'($urandom_range(0, 1));
          rdiv = $urandom_range(0, 2);
          cfg_div = 16'(rdiv); cfg_parity = rp; cfg_stop2 = rss;
          exp_q.push_back(model(rd, rp, rb, rs1, rs2, rss));
          send_frame(rd, 8, rp, rb, rs1, rs2, rss, 16 * (rdiv + 1), 1'b1, 1);
        end
        send_done = 1'b1;
      end
      reader(1'b0, "rand8");
    join
    check("rand8_ovr", 32'(ovr8), 0);

    // DATA_W=9, no parity, 256 back-to-back frames
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cfg_div = 16'd0; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    repeat (5) @(negedge clk);
    send_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          exp_q.push_back(model(9'(i), 2'b00, 1'b0, 1'b1, 1'b1, 1'b0));
          send_frame(9'(i), 9, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 16, 1'b0, 0);
        end
        drive_bit(1'b1, 64);
        send_done = 1'b1;
      end
      reader(1'b1, "b2b9");
    join
    check("b2b9_ovr", 32'(ovr9), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
